iq_symbol_mapper: RTL

//  Upstream feeder for the iq modulator. Accepts payload bytes over a

---
 rtl/iq_symbol_mapper_if.sv | 20 ++
 rtl/iq_symbol_mapper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iq_symbol_mapper_if.sv
// rtl/iq_symbol_mapper_if.sv - payload byte stream into the IQ symbol mapper
interface iq_symbol_mapper_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  // Byte source side
  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  // Mapper side
  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/iq_symbol_mapper.sv
// rtl/iq_symbol_mapper.sv - byte FIFO, 16-QAM Gray mapper and symbol hold timer
module iq_symbol_mapper #(
  parameter int SYMLEN     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  iq_symbol_mapper_if.slave   in_if,
  output logic [3:0]          i_o,
  output logic [3:0]          q_o,
  output logic                sym_strobe_o,
  output logic                busy_o
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(SYMLEN);
  localparam logic [AW:0]     FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(SYMLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYM_HI,
    SYM_LO
  } state_t;

  // Byte FIFO storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Symbol sequencer state and registered outputs
  state_t        state_q;
  logic [CW-1:0] hold_q;
  logic [3:0]    lo_nib_q;
  logic [3:0]    i_q;
  logic [3:0]    q_q;
  logic          strobe_q;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [7:0]    head;
  logic [3:0]    head_i;
  logic [3:0]    head_q;
  logic [3:0]    lo_i;
  logic [3:0]    lo_q;

  // Gray-coded 2-bit group to signed 4-bit amplitude level
  function automatic logic [3:0] gray_level(input logic [1:0] bits);
    logic [3:0] lvl;
    case (bits)
      2'b00:   lvl = 4'hA;  // -6
      2'b01:   lvl = 4'hE;  // -2
      2'b11:   lvl = 4'h2;  // +2
      default: lvl = 4'h6;  // +6
    endcase
    return lvl;
  endfunction

  // Ready depends only on occupancy so the source never sees a same-cycle pop
  assign fifo_empty      = (count_q == '0);
  assign in_if.din_ready = (count_q != FULL_CNT);
  assign push            = in_if.din_valid && in_if.din_ready;
  assign head            = mem_q[rd_ptr_q];

  assign head_i = gray_level(head[7:6]);
  assign head_q = gray_level(head[5:4]);
  assign lo_i   = gray_level(lo_nib_q[3:2]);
  assign lo_q   = gray_level(lo_nib_q[1:0]);

  // A byte leaves the FIFO whenever the sequencer starts a new high nibble
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == IDLE) begin
        pop = 1'b1;
      end else if (state_q == SYM_LO && hold_q == '0) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO data storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.din;
    end
  end

  // Symbol sequencer: high nibble, low nibble, each held SYMLEN clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      lo_nib_q <= '0;
      i_q      <= '0;
      q_q      <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            i_q      <= head_i;
            q_q      <= head_q;
            lo_nib_q <= head[3:0];
            hold_q   <= HOLD_LAST;
            strobe_q <= 1'b1;
            state_q  <= SYM_HI;
          end else begin
            i_q <= '0;
            q_q <= '0;
          end
        end
        SYM_HI: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - CW'(1);
          end else begin
            i_q      <= lo_i;
            q_q      <= lo_q;
            hold_q   <= HOLD_LAST;
            strobe_q <= 1'b1;
            state_q  <= SYM_LO;
          end
        end
        SYM_LO: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - CW'(1);
          end else if (!fifo_empty) begin
            // Next byte follows with no gap between symbols
            i_q      <= head_i;
            q_q      <= head_q;
            lo_nib_q <= head[3:0];
            hold_q   <= HOLD_LAST;
            strobe_q <= 1'b1;
            state_q  <= SYM_HI;
          end else begin
            i_q     <= '0;
            q_q     <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          i_q     <= '0;
          q_q     <= '0;
          hold_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_o          = i_q;
  assign q_o          = q_q;
  assign sym_strobe_o = strobe_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;

endmodule
